// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared encodings and constants for the BCD stopwatch controller and its digit cells.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVF   = 2'b11
    } state_t;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command/status bundle between a stopwatch user (master) and the controller (slave).
interface bcd_stopwatch_ctrl_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) ();

    // Commands are single-cycle pulses sampled on the rising clock edge; there is no
    // ready/backpressure, every pulse is acted on in the cycle it is seen.
    logic                    start;
    logic                    stop;
    logic                    clear;
    logic                    lap;
    logic [4*DIGITS-1:0]     count;
    logic [4*DIGITS-1:0]     lap_value;
    logic                    lap_valid;
    logic                    running;
    logic                    overflow;
    state_t                  state;

    modport master (
        output start, stop, clear, lap,
        input  count, lap_value, lap_valid, running, overflow, state
    );

    modport slave (
        input  start, stop, clear, lap,
        output count, lap_value, lap_valid, running, overflow, state
    );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit: wraps 9->0 on inc, clr dominates, hold freezes the digit for saturation.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !hold) begin
            q <= (q == BCD_MAX) ? '0 : q + 1'b1;
        end
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/clear/lap stopwatch: FSM gates prescaler ticks into a cascaded BCD digit chain.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int PW       = 4
) (
    input logic                  CLK,
    input logic                  Reset,
    bcd_stopwatch_ctrl_if.slave  bus
);

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    state_t              state;
    state_t              next_state;
    logic [PW-1:0]       presc;
    logic                adv;
    logic                tick;
    logic                all_nines;
    logic                lap_take;
    logic                carry;
    logic [DIGITS-1:0]   at_max;
    logic [DIGITS-1:0]   inc;
    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] lap_value_q;
    logic                lap_valid_q;

    // A stop or clear in the same cycle suppresses both the prescaler step and the tick.
    assign adv       = (state == ST_RUN) && !bus.clear && !bus.stop;
    assign tick      = adv && (presc == PRESC_MAX);
    assign all_nines = &at_max;
    assign lap_take  = bus.lap && !bus.clear && ((state == ST_RUN) || (state == ST_PAUSE));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.clear) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.start && !bus.stop) next_state = ST_RUN;
                ST_RUN: begin
                    if (bus.stop)                 next_state = ST_PAUSE;
                    else if (tick && all_nines)   next_state = ST_OVF;
                end
                ST_PAUSE: if (bus.start && !bus.stop) next_state = ST_RUN;
                default:  next_state = state;
            endcase
        end
    end

    always_comb begin
        bus.running  = (state == ST_RUN);
        bus.overflow = (state == ST_OVF);
        bus.state    = state;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
        end else if (bus.clear) begin
            presc <= '0;
        end else if (adv) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Ripple enable: digit i steps only when every lower digit is at 9.
    always_comb begin
        carry = tick;
        inc   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            inc[i] = carry;
            carry  = carry & at_max[i];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .CLK    (CLK),
            .Reset  (Reset),
            .clr    (bus.clear),
            .inc    (inc[g]),
            .hold   (all_nines),
            .q      (count_q[g*BCD_W +: BCD_W]),
            .at_max (at_max[g])
        );
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            lap_value_q <= '0;
            lap_valid_q <= 1'b0;
        end else if (bus.clear) begin
            lap_value_q <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_valid_q <= lap_take;
            if (lap_take) lap_value_q <= count_q;
        end
    end

    assign bus.count     = count_q;
    assign bus.lap_value = lap_value_q;
    assign bus.lap_valid = lap_valid_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: decimal-arithmetic stopwatch model checked every cycle plus directed literals.
module tb_bcd_stopwatch_ctrl;
    import bcd_pkg::*;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 2;
    localparam int PW       = 2;
    localparam int W        = 4 * DIGITS;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // model: mode 0 idle, 1 run, 2 pause, 3 overflow; value kept as a plain integer
    int m_mode = 0;
    int m_val  = 0;
    int m_ph   = 0;
    int m_lap  = 0;
    bit m_lv   = 1'b0;

    bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_stopwatch_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .PW(PW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic int max_val();
        int m = 1;
        for (int i = 0; i < DIGITS; i++) m = m * 10;
        return m - 1;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_mode = 0; m_val = 0; m_ph = 0; m_lap = 0; m_lv = 1'b0;
        end else begin
            m_lv = 1'b0;
            if (bus.clear) begin
                m_mode = 0; m_val = 0; m_ph = 0; m_lap = 0;
            end else begin
                if (bus.lap && (m_mode == 1 || m_mode == 2)) begin
                    m_lap = m_val;
                    m_lv  = 1'b1;
                end
                case (m_mode)
                    0: if (bus.start && !bus.stop) m_mode = 1;
                    1: begin
                        if (bus.stop) m_mode = 2;
                        else if (m_ph == PRESCALE - 1) begin
                            m_ph = 0;
                            if (m_val == max_val()) m_mode = 3;
                            else m_val = m_val + 1;
                        end else m_ph = m_ph + 1;
                    end
                    2: if (bus.start && !bus.stop) m_mode = 1;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_count", bus.count, to_bcd(m_val));
            check("model_lap_value", bus.lap_value, to_bcd(m_lap));
            check("model_lap_valid", W'(bus.lap_valid), W'(m_lv));
            check("model_running", W'(bus.running), W'(m_mode == 1));
            check("model_overflow", W'(bus.overflow), W'(m_mode == 3));
            check("model_state", W'(bus.state), W'(m_mode));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input bit s, input bit p, input bit c, input bit l);
        bus.start = s; bus.stop = p; bus.clear = c; bus.lap = l;
        @(negedge CLK);
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
        #1 Reset = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset  = 1'b0;
        cmp_en = 1'b1;
        check("rst_count", bus.count, 8'h00);
        check("rst_lap_value", bus.lap_value, 8'h00);
        check("rst_running", W'(bus.running), 8'h00);
        check("rst_overflow", W'(bus.overflow), 8'h00);
        wait_n(10);
        check("idle_no_tick", bus.count, 8'h00);

        // basic count
        pulse(1, 0, 0, 0);
        check("start_running", W'(bus.running), 8'h01);
        wait_n(20);
        check("count_20cyc", bus.count, 8'h10);

        // pause / resume with stop landing on a tick cycle
        pulse(0, 0, 1, 0);
        check("clear_count", bus.count, 8'h00);
        pulse(1, 0, 0, 0);
        wait_n(10);
        check("pause_pre", bus.count, 8'h05);
        wait_n(1);
        pulse(0, 1, 0, 0);
        check("stop_running", W'(bus.running), 8'h00);
        check("stop_on_tick", bus.count, 8'h05);
        wait_n(50);
        check("pause_hold", bus.count, 8'h05);
        pulse(0, 0, 0, 1);
        check("pause_lap_value", bus.lap_value, 8'h05);
        check("pause_lap_valid", W'(bus.lap_valid), 8'h01);
        wait_n(1);
        check("pause_lap_valid_drop", W'(bus.lap_valid), 8'h00);
        pulse(1, 0, 0, 0);
        check("resume_running", W'(bus.running), 8'h01);
        check("resume_hold", bus.count, 8'h05);
        wait_n(1);
        check("resume_tick", bus.count, 8'h06);

        // lap coincident with tick
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        wait_n(75);
        check("lap_pre_count", bus.count, 8'h37);
        pulse(0, 0, 0, 1);
        check("lap_tick_value", bus.lap_value, 8'h37);
        check("lap_tick_valid", W'(bus.lap_valid), 8'h01);
        check("lap_tick_count", bus.count, 8'h38);
        wait_n(1);
        check("lap_valid_once", W'(bus.lap_valid), 8'h00);

        // overflow
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        wait_n(200);
        check("ovf_count", bus.count, 8'h99);
        check("ovf_flag", W'(bus.overflow), 8'h01);
        check("ovf_running", W'(bus.running), 8'h00);
        pulse(1, 0, 0, 0);
        check("ovf_ign_start", W'(bus.overflow), 8'h01);
        pulse(0, 0, 0, 1);
        check("ovf_ign_lap", W'(bus.lap_valid), 8'h00);
        pulse(0, 1, 0, 0);
        check("ovf_ign_stop", W'(bus.overflow), 8'h01);
        check("ovf_sat", bus.count, 8'h99);
        pulse(0, 0, 1, 0);
        check("ovf_clear_flag", W'(bus.overflow), 8'h00);
        check("ovf_clear_count", bus.count, 8'h00);

        // priority
        pulse(1, 1, 0, 0);
        check("start_stop_idle", W'(bus.running), 8'h00);
        pulse(1, 0, 0, 0);
        wait_n(3);
        pulse(0, 0, 1, 1);
        check("clear_lap_running", W'(bus.running), 8'h00);
        check("clear_lap_valid", W'(bus.lap_valid), 8'h00);
        check("clear_lap_count", bus.count, 8'h00);

        // asynchronous reset mid-run
        pulse(1, 0, 0, 0);
        wait_n(6);
        pulse(0, 0, 0, 1);
        check("pre_rst_lap", bus.lap_value, 8'h03);
        wait_n(2);
        #2 Reset = 1'b1;
        #1;
        check("async_count", bus.count, 8'h00);
        check("async_lap_value", bus.lap_value, 8'h00);
        check("async_running", W'(bus.running), 8'h00);
        @(negedge CLK);
        Reset = 1'b0;
        wait_n(5);
        check("post_rst_idle", bus.count, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
